// File: rtl/register_serializer.sv
// Parallel-in, serial-out readback stage: buffers one register word and streams
// it onto a single wire at a programmable bit period, with frame valid/strobe/done.
module register_serializer #(
  parameter int REG_WIDTH    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                 clk,
  input  logic                 a_reset_n,
  input  logic                 clear,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [REG_WIDTH-1:0] data_in,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 bit_strobe,
  output logic                 done
);

  localparam int BIT_W = $clog2(REG_WIDTH);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(REG_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state, state_next;
  logic [REG_WIDTH-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]     bit_cnt, bit_next;
  logic [DIV_W-1:0]     div_cnt, div_next;
  logic                 done_q, done_next;

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_next;
      div_cnt   <= div_next;
      done_q    <= done_next;
    end
  end

  // clear outranks frame completion, so a clear in the last cycle suppresses done
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    bit_next   = bit_cnt;
    div_next   = div_cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid && !clear) begin
          state_next = SHIFT;
          shift_next = data_in;
          bit_next   = '0;
          div_next   = '0;
        end
      end
      SHIFT: begin
        if (clear) begin
          state_next = IDLE;
          shift_next = '0;
          bit_next   = '0;
          div_next   = '0;
        end else if (div_cnt == DIV_LAST) begin
          div_next   = '0;
          shift_next = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
          if (bit_cnt == BIT_LAST) begin
            state_next = IDLE;
            bit_next   = '0;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_ready = (state == IDLE);
  assign ser_valid  = (state == SHIFT);
  assign bit_strobe = (state == SHIFT) && (div_cnt == '0);
  assign ser_out    = (state == SHIFT) &&
                      (MSB_FIRST ? shift_reg[REG_WIDTH-1] : shift_reg[0]);
  assign done       = done_q;

endmodule

// File: tb/tb_register_serializer.sv
// Self-checking bench for register_serializer: a cycle-index frame model checked
// every cycle on two instances (8/4/MSB-first and 8/1/LSB-first), plus literal pins.
module tb_register_serializer;

   logic       clk = 1'b0;
   logic       a_reset_n;
   logic [1:0] clear;
   logic [1:0] load_valid;
   logic [7:0] data_in [2];
   logic [1:0] load_ready, ser_out, ser_valid, bit_strobe, done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // frame model: p = position within frame (1..8*cpb), 0 when idle
   int         p [2]     = '{0, 0};
   logic [7:0] mword [2] = '{8'h00, 8'h00};
   logic       mdone [2] = '{1'b0, 1'b0};

   // observation of what each DUT actually emitted
   logic [15:0] cap [2];
   int strobes [2], valid_cnt [2], done_cnt [2], acc_n [2];
   int acc_hist [2][4];
   int done_hist [2][4];

   always #5 clk = ~clk;

   register_serializer #(.REG_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .a_reset_n(a_reset_n), .clear(clear[0]), .load_valid(load_valid[0]),
      .load_ready(load_ready[0]), .data_in(data_in[0]), .ser_out(ser_out[0]),
      .ser_valid(ser_valid[0]), .bit_strobe(bit_strobe[0]), .done(done[0]));

   register_serializer #(.REG_WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .a_reset_n(a_reset_n), .clear(clear[1]), .load_valid(load_valid[1]),
      .load_ready(load_ready[1]), .data_in(data_in[1]), .ser_out(ser_out[1]),
      .ser_valid(ser_valid[1]), .bit_strobe(bit_strobe[1]), .done(done[1]));

   function automatic int cpb(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic bit msbf(input int i);
      return (i == 0);
   endfunction

   task automatic checkOutput(input string name, input int idx, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("[TB] FAIL %s[%0d]: got %0d, expected %0d (cycle %0d)", name, idx, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input int i, input logic lv, input logic [7:0] d, input logic clr);
      @(posedge clk); #1;
      load_valid[i] = lv;
      data_in[i]    = d;
      clear[i]      = clr;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic waitDone(input int i, input int target, input int budget);
      int k = 0;
      while (done_cnt[i] < target && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      if (done_cnt[i] < target) checkOutput("done_timeout", i, done_cnt[i], target);
   endtask

   task automatic waitAcc(input int i, input int target, input int budget);
      int k = 0;
      while (acc_n[i] < target && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      if (acc_n[i] < target) checkOutput("accept_timeout", i, acc_n[i], target);
   endtask

   task automatic waitUntilCycle(input int target, input int budget);
      int k = 0;
      while (cyc < target && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      if (cyc != target) checkOutput("cycle_timeout", 0, cyc, target);
   endtask

   task automatic clearMon(input int i);
      cap[i]       = '0;
      strobes[i]   = 0;
      valid_cnt[i] = 0;
      done_cnt[i]  = 0;
      acc_n[i]     = 0;
   endtask

   task automatic checkResetValues(input string name, input int i);
      checkOutput({name, "_ready"},  i, int'(load_ready[i]), 1);
      checkOutput({name, "_out"},    i, int'(ser_out[i]), 0);
      checkOutput({name, "_valid"},  i, int'(ser_valid[i]), 0);
      checkOutput({name, "_strobe"}, i, int'(bit_strobe[i]), 0);
      checkOutput({name, "_done"},   i, int'(done[i]), 0);
   endtask

   always @(posedge clk) cyc++;

   // Advance the frame model at each edge: a frame lasts 8*cpb cycles, done follows it,
   // clear abandons it, and a word is taken only while idle (including the done cycle).
   always @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         for (int i = 0; i < 2; i++) begin
            p[i]     = 0;
            mdone[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (p[i] > 0) begin
               if (clear[i]) begin
                  p[i] = 0;
                  mdone[i] = 1'b0;
               end else if (p[i] == 8 * cpb(i)) begin
                  p[i] = 0;
                  mdone[i] = 1'b1;
               end else begin
                  p[i] = p[i] + 1;
                  mdone[i] = 1'b0;
               end
            end else begin
               mdone[i] = 1'b0;
               if (load_valid[i] && !clear[i]) begin
                  p[i] = 1;
                  mword[i] = data_in[i];
               end
            end
         end
      end
   end

   // Compare every output of both instances against the model on the falling edge,
   // then record what was actually emitted for the literal checks.
   always @(negedge clk) begin
      logic e_out, e_val, e_stb, e_rdy, e_done;
      int n, idx;
      for (int i = 0; i < 2; i++) begin
         if (!a_reset_n) begin
            e_rdy = 1'b1; e_out = 1'b0; e_val = 1'b0; e_stb = 1'b0; e_done = 1'b0;
         end else begin
            e_val  = (p[i] > 0);
            e_rdy  = (p[i] == 0);
            e_done = mdone[i];
            if (p[i] > 0) begin
               n     = (p[i] - 1) / cpb(i);
               idx   = msbf(i) ? 7 - n : n;
               e_out = mword[i][idx];
               e_stb = (((p[i] - 1) % cpb(i)) == 0);
            end else begin
               e_out = 1'b0;
               e_stb = 1'b0;
            end
         end
         checkOutput("load_ready", i, int'(load_ready[i]), int'(e_rdy));
         checkOutput("ser_out",    i, int'(ser_out[i]),    int'(e_out));
         checkOutput("ser_valid",  i, int'(ser_valid[i]),  int'(e_val));
         checkOutput("bit_strobe", i, int'(bit_strobe[i]), int'(e_stb));
         checkOutput("done",       i, int'(done[i]),       int'(e_done));
         if (a_reset_n) begin
            if (bit_strobe[i]) begin
               strobes[i]++;
               cap[i] = (i == 0) ? {cap[i][14:0], ser_out[i]} : {ser_out[i], cap[i][15:1]};
            end
            if (ser_valid[i]) valid_cnt[i]++;
            if (done[i]) begin
               if (done_cnt[i] < 4) done_hist[i][done_cnt[i]] = cyc;
               done_cnt[i]++;
            end
            if (load_ready[i] && load_valid[i] && !clear[i]) begin
               if (acc_n[i] < 4) acc_hist[i][acc_n[i]] = cyc;
               acc_n[i]++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      a_reset_n  = 1'b0;
      clear      = '0;
      load_valid = '0;
      data_in[0] = 8'h00;
      data_in[1] = 8'h00;
      clearMon(0);
      clearMon(1);

      // reset state
      idleCycles(2);
      checkResetValues("rst", 0);
      checkResetValues("rst", 1);
      a_reset_n = 1'b1;
      idleCycles(2);

      // single frame 0xA5 with busy-ignore of 0xFF
      $display("[TB] single frame 0xA5, MSB first, 4 clocks per bit");
      clearMon(0);
      applyStimulus(0, 1'b1, 8'hA5, 1'b0);
      applyStimulus(0, 1'b0, 8'h00, 1'b0);
      idleCycles(4);
      load_valid[0] = 1'b1;
      data_in[0]    = 8'hFF;
      repeat (6) begin
         idleCycles(1);
         checkOutput("busy_ready", 0, int'(load_ready[0]), 0);
      end
      load_valid[0] = 1'b0;
      waitDone(0, 1, 60);
      idleCycles(3);
      checkOutput("a5_word",    0, int'(cap[0][7:0]), 'hA5);
      checkOutput("a5_strobes", 0, strobes[0], 8);
      checkOutput("a5_valid",   0, valid_cnt[0], 32);
      checkOutput("a5_accepts", 0, acc_n[0], 1);
      checkOutput("a5_done_at", 0, done_hist[0][0] - acc_hist[0][0], 33);
      checkOutput("a5_dones",   0, done_cnt[0], 1);

      // LSB first, one clock per bit
      $display("[TB] single frame 0x01, LSB first, 1 clock per bit");
      clearMon(1);
      applyStimulus(1, 1'b1, 8'h01, 1'b0);
      applyStimulus(1, 1'b0, 8'h00, 1'b0);
      waitDone(1, 1, 30);
      idleCycles(2);
      checkOutput("lsb_word",    1, int'(cap[1][15:8]), 'h01);
      checkOutput("lsb_strobes", 1, strobes[1], 8);
      checkOutput("lsb_valid",   1, valid_cnt[1], 8);
      checkOutput("lsb_done_at", 1, done_hist[1][0] - acc_hist[1][0], 9);

      // back-to-back frames
      $display("[TB] back-to-back 0x3C then 0xC3");
      clearMon(0);
      applyStimulus(0, 1'b1, 8'h3C, 1'b0);
      applyStimulus(0, 1'b1, 8'hC3, 1'b0);
      waitAcc(0, 2, 60);
      load_valid[0] = 1'b0;
      waitDone(0, 2, 80);
      idleCycles(2);
      checkOutput("b2b_words",   0, int'(cap[0]), 'h3CC3);
      checkOutput("b2b_strobes", 0, strobes[0], 16);
      checkOutput("b2b_valid",   0, valid_cnt[0], 64);
      checkOutput("b2b_spacing", 0, acc_hist[0][1] - acc_hist[0][0], 33);
      checkOutput("b2b_on_done", 0, acc_hist[0][1], done_hist[0][0]);
      checkOutput("b2b_done2",   0, done_hist[0][1] - acc_hist[0][1], 33);

      // clear during bit 3, then a clean frame
      $display("[TB] clear mid-frame, then 0x81");
      clearMon(0);
      applyStimulus(0, 1'b1, 8'h5A, 1'b0);
      applyStimulus(0, 1'b0, 8'h00, 1'b0);
      waitUntilCycle(acc_hist[0][0] + 14, 40);
      clear[0] = 1'b1;
      idleCycles(1);
      clear[0] = 1'b0;
      checkOutput("clr_valid", 0, int'(ser_valid[0]), 0);
      checkOutput("clr_ready", 0, int'(load_ready[0]), 1);
      idleCycles(40);
      checkOutput("clr_no_done", 0, done_cnt[0], 0);
      clearMon(0);
      applyStimulus(0, 1'b1, 8'h81, 1'b0);
      applyStimulus(0, 1'b0, 8'h00, 1'b0);
      waitDone(0, 1, 60);
      idleCycles(2);
      checkOutput("x81_word",    0, int'(cap[0][7:0]), 'h81);
      checkOutput("x81_strobes", 0, strobes[0], 8);

      // clear in idle blocks acceptance
      $display("[TB] clear while idle");
      clearMon(1);
      applyStimulus(1, 1'b1, 8'h77, 1'b1);
      idleCycles(2);
      checkOutput("idle_clr_valid", 1, int'(ser_valid[1]), 0);
      applyStimulus(1, 1'b0, 8'h00, 1'b0);
      idleCycles(2);
      checkOutput("idle_clr_acc", 1, acc_n[1], 0);

      // clear in the last cycle of a frame suppresses done
      $display("[TB] clear in last bit cycle");
      clearMon(1);
      applyStimulus(1, 1'b1, 8'hFF, 1'b0);
      applyStimulus(1, 1'b0, 8'h00, 1'b0);
      waitUntilCycle(acc_hist[1][0] + 8, 20);
      clear[1] = 1'b1;
      idleCycles(1);
      clear[1] = 1'b0;
      checkOutput("last_clr_done",  1, int'(done[1]), 0);
      checkOutput("last_clr_valid", 1, int'(ser_valid[1]), 0);
      idleCycles(5);
      checkOutput("last_clr_dones", 1, done_cnt[1], 0);

      // asynchronous reset mid-frame
      $display("[TB] asynchronous reset mid-frame");
      clearMon(0);
      applyStimulus(0, 1'b1, 8'hFF, 1'b0);
      applyStimulus(0, 1'b0, 8'h00, 1'b0);
      waitUntilCycle(acc_hist[0][0] + 10, 30);
      checkOutput("pre_rst_out", 0, int'(ser_out[0]), 1);
      a_reset_n = 1'b0;
      #1;
      checkResetValues("async_rst", 0);
      idleCycles(2);
      a_reset_n = 1'b1;
      idleCycles(3);
      checkResetValues("post_rst", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/register_serializer.md
# register_serializer

Parallel-in, serial-out readback stage that takes a REG_WIDTH-bit word from a register output and shifts it out one bit at a time at a programmable bit period. It is the read side of the board's register path: a word held in a generic register is offered here with a valid/ready handshake and is streamed to a single-wire consumer, such as a debug pin, an LED chain or a downstream deserializer. The block buffers one word and does not accept a new word until the current frame completes or is cleared.

## Interface
- REG_WIDTH, 8, word width in bits (≥2)
- CLKS_PER_BIT, 4, clk cycles per serial bit (≥1)
- MSB_FIRST, 1, 1 = bit REG_WIDTH-1 first; 0 = bit 0 first

- clk  in  1  clock; all logic on rising edge
- a_reset_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort; returns to IDLE without done
- load_valid  in  1  data_in holds a word to send
- load_ready  out  1  block can accept a word (high only in IDLE)
- data_in  in  REG_WIDTH  word, sampled only on acceptance
- ser_out  out  1  current serial bit
- ser_valid  out  1  high for every cycle of a frame
- bit_strobe  out  1  one-cycle pulse in the first cycle of each bit
- done  out  1  one-cycle pulse after the last bit period ends

## Operation
- Reset (a_reset_n=0, any time, including mid-frame): state=IDLE; shift register, bit counter and divider cleared; load_ready=1; ser_out=0, ser_valid=0, bit_strobe=0, done=0.
- The block has two states: IDLE and SHIFT.
- IDLE:
  - load_ready=1, ser_valid=0, ser_out=0.
  - Acceptance occurs at the edge where load_valid=1 and load_ready=1 and clear=0.
  - On acceptance: data_in is captured into the shift register, bit_cnt=0 and div_cnt=0, and the state moves to SHIFT.
- SHIFT:
  - load_ready=0 and ser_valid=1.
  - ser_out is the current bit of the shift register: the MSB when MSB_FIRST=1, otherwise the LSB.
  - div_cnt counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1 it wraps to 0, the register shifts by one (toward the output end, zero-fill) and bit_cnt increments.
  - When div_cnt=CLKS_PER_BIT-1 and bit_cnt=REG_WIDTH-1, the state moves to IDLE and done is registered high for the next cycle.
- bit_strobe=1 exactly when state=SHIFT and div_cnt=0.
- load_valid while busy is ignored. No word is queued and data_in is not sampled.
- clear:
  - In SHIFT, the next state is IDLE with counters zeroed, done=0 and ser_out=0.
  - In IDLE, clear blocks acceptance for that cycle.
  - clear has priority over frame completion: if clear is asserted in the last cycle of a frame, no done pulse is produced.
- The done cycle is an IDLE cycle, so load_ready=1 during it and a new word may be accepted at that same edge (back-to-back frames).
- With CLKS_PER_BIT=1, every SHIFT cycle carries a new bit and bit_strobe is high throughout the frame.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

## Timing
- Accept at edge k. The first bit appears on ser_out, with ser_valid=1 and bit_strobe=1, in cycle k+1.
- Bit n (0-based, in transmit order) occupies cycles k+1+n·CLKS_PER_BIT .. k+(n+1)·CLKS_PER_BIT.
- Frame length is REG_WIDTH·CLKS_PER_BIT cycles with ser_valid=1.
- done=1 in cycle k+1+REG_WIDTH·CLKS_PER_BIT, the first cycle after the frame.
- Maximum throughput is one word per REG_WIDTH·CLKS_PER_BIT+1 cycles. ser_valid therefore drops for at least one cycle between frames.
- A clear sampled at edge j causes ser_valid=0 and load_ready=1 from cycle j+1.

## Test plan
- Reset: hold a_reset_n=0, then release. Required: load_ready=1 and ser_out=ser_valid=bit_strobe=done=0. Pulling a_reset_n low mid-frame forces the same values immediately, without waiting for a clock edge.
- Single frame, defaults: accept 0xA5. Required: ser_out reads 1,0,1,0,0,1,0,1 with each bit held for 4 cycles, 8 bit_strobe pulses, ser_valid high for 32 cycles, and done high exactly at accept+33.
- LSB first, MSB_FIRST=0, CLKS_PER_BIT=1: accept 0x01. Required: ser_out=1 for one cycle followed by 7 zeros, bit_strobe high for all 8 cycles, and done at accept+9.
- Back-to-back: keep load_valid=1 with 0x3C followed by 0xC3. Required: the second word is accepted on the done edge, the inter-frame gap is exactly 1 cycle, and both bit streams are correct.
- Busy ignore: during the 0xA5 frame, change data_in to 0xFF with load_valid=1. Required: the frame still transmits 0xA5 and load_ready stays 0 until the done cycle.
- Clear mid-frame: assert clear during bit 3. Required: in the next cycle ser_valid=0 and load_ready=1, no done pulse occurs, and a following accept of 0x81 transmits correctly from bit 0.
